// File: rtl/fpu_rptr_pkg.sv
// Shared definitions for the fpu_rptr skid stage family.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: state_t (occupancy-encoded FSM state), WIDTH_DEF (default data width).
package fpu_rptr_pkg;

  localparam int WIDTH_DEF = 64;

  // State value doubles as the held-entry count driven on occ.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/fpu_rptr_dffe.sv
// WIDTH-wide enabled data register, async active-low clear to zero.
// Latency: 1 cycle from en to q.
// Backpressure: none; q holds whenever en is low.
// Ports: clk, rst_l (async active-low), en (load strobe), d (next value), q (held value).
module fpu_rptr_dffe #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fpu_rptr_skid64.sv
// Two-entry skid buffer: main register drives out_*, skid register absorbs one beat.
// Latency: 1 cycle from accepted input to out_vld when empty; full 1/cycle throughput.
// Backpressure: in_rdy is registered and drops only when both entries are held.
// Ports: rclk, arst_l, flush; in_vld/in_data/in_rdy upstream; out_vld/out_data/out_rdy
//        downstream; occ = held entry count (0..2). All outputs come straight from flops.
module fpu_rptr_skid64
  import fpu_rptr_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             rclk,
  input  logic             arst_l,
  input  logic             flush,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_rdy,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_rdy,
  output logic [1:0]       occ
);

  state_t           state, state_nxt;
  logic             in_rdy_q, out_vld_q;
  logic             acc_in, acc_out;
  logic             main_en, skid_en, main_sel_skid;
  logic [WIDTH-1:0] main_d, skid_q;

  // in_rdy_q is only high outside TWO, so an input can never land in a full stage.
  assign acc_in  = in_vld & in_rdy_q;
  assign acc_out = out_vld_q & out_rdy;

  always_comb begin
    state_nxt     = state;
    main_en       = 1'b0;
    skid_en       = 1'b0;
    main_sel_skid = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (acc_in) begin
          state_nxt = ST_ONE;
          main_en   = 1'b1;
        end
      end
      ST_ONE: begin
        case ({acc_in, acc_out})
          2'b10:   begin state_nxt = ST_TWO;   skid_en = 1'b1; end
          2'b01:   begin state_nxt = ST_EMPTY;                 end
          2'b11:   begin state_nxt = ST_ONE;   main_en = 1'b1; end
          default: begin state_nxt = ST_ONE;                   end
        endcase
      end
      ST_TWO: begin
        if (acc_out) begin
          state_nxt     = ST_ONE;
          main_en       = 1'b1;
          main_sel_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // Flush wins over any same-cycle transfer; data registers keep their contents.
    if (flush) begin
      state_nxt = ST_EMPTY;
      main_en   = 1'b0;
      skid_en   = 1'b0;
    end
  end

  assign main_d = main_sel_skid ? skid_q : in_data;

  // Handshake flags are registered copies of the next-state decode.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state     <= ST_EMPTY;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_rdy_q  <= (state_nxt != ST_TWO);
      out_vld_q <= (state_nxt != ST_EMPTY);
    end
  end

  fpu_rptr_dffe #(.WIDTH(WIDTH)) u_main (
    .clk   (rclk),
    .rst_l (arst_l),
    .en    (main_en),
    .d     (main_d),
    .q     (out_data)
  );

  fpu_rptr_dffe #(.WIDTH(WIDTH)) u_skid (
    .clk   (rclk),
    .rst_l (arst_l),
    .en    (skid_en),
    .d     (in_data),
    .q     (skid_q)
  );

  assign in_rdy  = in_rdy_q;
  assign out_vld = out_vld_q;
  assign occ     = state;

endmodule

// File: tb/tb_fpu_rptr_skid64.sv
module tb_fpu_rptr_skid64;

  logic        rclk;
  logic        arst_l;
  logic        flush;
  logic        in_vld;
  logic [63:0] in_data;
  logic        in_rdy;
  logic        out_vld;
  logic [63:0] out_data;
  logic        out_rdy;
  logic [1:0]  occ;

  logic        f32, iv32, ir32, ov32, or32;
  logic [31:0] id32, od32;
  logic [1:0]  oc32;

  int n_chk  = 0;
  int n_pass = 0;

  fpu_rptr_skid64 #(.WIDTH(64)) dut (
    .rclk(rclk), .arst_l(arst_l), .flush(flush),
    .in_vld(in_vld), .in_data(in_data), .in_rdy(in_rdy),
    .out_vld(out_vld), .out_data(out_data), .out_rdy(out_rdy), .occ(occ)
  );

  fpu_rptr_skid64 #(.WIDTH(32)) dut32 (
    .rclk(rclk), .arst_l(arst_l), .flush(f32),
    .in_vld(iv32), .in_data(id32), .in_rdy(ir32),
    .out_vld(ov32), .out_data(od32), .out_rdy(or32), .occ(oc32)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // Reference model: an ordered list of held entries, at most two.
  logic [63:0] mq[$];
  logic [63:0] m_shown = '0;
  bit          m_pop, m_push;
  int          rx_cnt  = 0;
  int          tx_next = 0;

  always @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      mq.delete();
      m_shown = '0;
    end else if (flush) begin
      mq.delete();
    end else begin
      m_pop  = (mq.size() > 0) && out_rdy;
      m_push = in_vld && (mq.size() < 2);
      if (m_pop)  begin void'(mq.pop_front()); rx_cnt++;  end
      if (m_push) begin mq.push_back(in_data); tx_next++; end
      if (mq.size() > 0) m_shown = mq[0];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Advance to the next falling edge and compare every DUT output with the model.
  task automatic tick();
    @(negedge rclk);
    chk("out_vld", {63'd0, out_vld}, (mq.size() > 0) ? 64'd1 : 64'd0);
    chk("in_rdy",  {63'd0, in_rdy},  (mq.size() < 2) ? 64'd1 : 64'd0);
    chk("occ",     {62'd0, occ},     64'(mq.size()));
    chk("out_data", out_data, m_shown);
  endtask

  initial begin
    int tx0, rx0;
    bit done;
    arst_l = 1'b0; flush = 1'b0; in_vld = 1'b0; in_data = '0; out_rdy = 1'b0;
    f32 = 1'b0; iv32 = 1'b0; id32 = '0; or32 = 1'b0;
    repeat (2) @(negedge rclk);
    arst_l = 1'b1;
    tick();
    chk("rst_occ",  {62'd0, occ}, 64'd0);
    chk("rst_rdy",  {63'd0, in_rdy}, 64'd1);
    chk("rst_vld",  {63'd0, out_vld}, 64'd0);
    chk("rst_data", out_data, 64'd0);

    // Single beat, 1-cycle latency, then empty with data held.
    in_vld = 1'b1; in_data = 64'h0123_4567_89AB_CDEF; out_rdy = 1'b1;
    tick();
    chk("lat_vld",  {63'd0, out_vld}, 64'd1);
    chk("lat_data", out_data, 64'h0123_4567_89AB_CDEF);
    in_vld = 1'b0;
    tick();
    chk("lat_empty", {62'd0, occ}, 64'd0);
    chk("lat_hold",  out_data, 64'h0123_4567_89AB_CDEF);

    // Fill to two, third refused, then drain in order.
    out_rdy = 1'b0; in_vld = 1'b1; in_data = 64'h1;
    tick();
    in_data = 64'h2;
    tick();
    in_data = 64'h3;
    chk("full_occ", {62'd0, occ}, 64'd2);
    chk("full_rdy", {63'd0, in_rdy}, 64'd0);
    tick();
    chk("full_hold", out_data, 64'h1);
    chk("full_occ2", {62'd0, occ}, 64'd2);
    out_rdy = 1'b1;
    tick();
    chk("drain_2", out_data, 64'h2);
    tick();
    chk("drain_3", out_data, 64'h3);
    in_vld = 1'b0;
    tick();
    chk("drain_empty", {63'd0, out_vld}, 64'd0);

    // Stream 1000 incrementing values with random backpressure.
    tx0 = tx_next; rx0 = rx_cnt; done = 0;
    for (int c = 0; c < 8000 && !done; c++) begin
      out_rdy = 1'($urandom_range(0, 1));
      if (tx_next - tx0 < 1000) begin
        in_vld = 1'b1; in_data = 64'(tx_next - tx0);
      end else begin
        in_vld = 1'b0;
      end
      tick();
      if (occ > 2'd2) chk("occ_max", {62'd0, occ}, 64'd2);
      if (rx_cnt - rx0 >= 1000) done = 1;
    end
    chk("stream_done", 64'(rx_cnt - rx0), 64'd1000);
    in_vld = 1'b0; out_rdy = 1'b1;
    repeat (3) tick();

    // Flush while full with a same-cycle input.
    out_rdy = 1'b0; in_vld = 1'b1; in_data = 64'hA;
    tick();
    in_data = 64'hB;
    tick();
    flush = 1'b1; in_data = 64'hC;
    tick();
    flush = 1'b0; in_vld = 1'b0;
    chk("fl_occ", {62'd0, occ}, 64'd0);
    chk("fl_vld", {63'd0, out_vld}, 64'd0);
    chk("fl_rdy", {63'd0, in_rdy}, 64'd1);
    out_rdy = 1'b1;
    repeat (3) tick();
    chk("fl_no_out", {63'd0, out_vld}, 64'd0);
    in_vld = 1'b1; in_data = 64'h55;
    tick();
    in_vld = 1'b0;
    chk("fl_next", out_data, 64'h55);
    tick();

    // Asynchronous reset pulse between edges while full.
    out_rdy = 1'b0; in_vld = 1'b1; in_data = 64'h11;
    tick();
    in_data = 64'h22;
    tick();
    in_data = 64'hFFFF;
    #2 arst_l = 1'b0;
    #1;
    chk("ar_vld",  {63'd0, out_vld}, 64'd0);
    chk("ar_occ",  {62'd0, occ}, 64'd0);
    chk("ar_rdy",  {63'd0, in_rdy}, 64'd1);
    chk("ar_data", out_data, 64'd0);
    #1 arst_l = 1'b1;
    tick();
    chk("ar_acc_vld",  {63'd0, out_vld}, 64'd1);
    chk("ar_acc_data", out_data, 64'hFFFF);
    out_rdy = 1'b1; in_vld = 1'b0;
    tick();
    chk("ar_drain", {63'd0, out_vld}, 64'd0);

    // 32-bit build: fill, refuse, drain in order.
    or32 = 1'b0; iv32 = 1'b1; id32 = 32'hDEAD_BEEF;
    @(negedge rclk);
    id32 = 32'h1;
    @(negedge rclk);
    id32 = 32'h3;
    chk("w32_occ", {62'd0, oc32}, 64'd2);
    chk("w32_rdy", {63'd0, ir32}, 64'd0);
    @(negedge rclk);
    chk("w32_hold", {32'd0, od32}, 64'hDEAD_BEEF);
    or32 = 1'b1;
    @(negedge rclk);
    chk("w32_d1",  {32'd0, od32}, 64'h1);
    chk("w32_rdy1", {63'd0, ir32}, 64'd1);
    @(negedge rclk);
    chk("w32_d3",  {32'd0, od32}, 64'h3);
    iv32 = 1'b0;
    @(negedge rclk);
    chk("w32_empty", {62'd0, oc32}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
